// File: rtl/lc3_mem_responder.sv
// Dual-port latency-configurable memory responder for the LC3 bench:
// read-only fetch port, read/write data port, preload path, sticky out-of-range flag.
module lc3_mem_responder #(
   parameter int unsigned         ADDR_W    = 16,
   parameter int unsigned         DATA_W    = 16,
   parameter int unsigned         MEM_DEPTH = 256,
   parameter logic [ADDR_W-1:0]   BASE_ADDR = ADDR_W'(16'h3000),
   parameter int unsigned         IMEM_LAT  = 1,
   parameter int unsigned         DMEM_LAT  = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              imem_rd,
   input  logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_dout,
   output logic              imem_complete,
   input  logic              dmem_req,
   input  logic              dmem_rd,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [DATA_W-1:0] dmem_din,
   output logic [DATA_W-1:0] dmem_dout,
   output logic              dmem_complete,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              err_oob
);

   localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
   localparam int unsigned CMP_W  = ADDR_W + 1;
   localparam int unsigned ICNT_W = $clog2(IMEM_LAT + 1);
   localparam int unsigned DCNT_W = $clog2(DMEM_LAT + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   // ---------------- fetch port ----------------
   logic [1:0]        i_state, i_state_nxt;
   logic [ICNT_W-1:0] i_cnt, i_cnt_nxt;
   logic [ADDR_W-1:0] i_addr_q, i_addr_nxt;
   logic              i_go_c;
   logic [ADDR_W-1:0] i_addr_c, i_off_c;
   logic              i_inr_c;
   logic [IDX_W-1:0]  i_idx_c;

   // With LAT=1 the response edge is the capture edge, so the live address is used
   always_comb begin
      i_addr_c = (i_state == ST_IDLE) ? imem_addr : i_addr_q;
      i_off_c  = i_addr_c - BASE_ADDR;
      i_inr_c  = CMP_W'(i_off_c) < CMP_W'(MEM_DEPTH);
      i_idx_c  = i_off_c[IDX_W-1:0];
   end

   always_comb begin
      i_state_nxt = i_state;
      i_cnt_nxt   = i_cnt;
      i_addr_nxt  = i_addr_q;
      i_go_c      = 1'b0;
      case (i_state)
         ST_IDLE: begin
            if (imem_rd) begin
               i_addr_nxt = imem_addr;
               if (IMEM_LAT == 1) begin
                  i_state_nxt = ST_RESP;
                  i_go_c      = 1'b1;
               end else begin
                  i_state_nxt = ST_WAIT;
                  i_cnt_nxt   = ICNT_W'(IMEM_LAT - 1);
               end
            end
         end
         ST_WAIT: begin
            i_cnt_nxt = i_cnt - ICNT_W'(1);
            if (i_cnt == ICNT_W'(1)) begin
               i_state_nxt = ST_RESP;
               i_go_c      = 1'b1;
            end
         end
         ST_RESP: i_state_nxt = ST_IDLE;
         default: i_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         i_state       <= ST_IDLE;
         i_cnt         <= '0;
         i_addr_q      <= '0;
         imem_dout     <= '0;
         imem_complete <= 1'b0;
      end else begin
         i_state       <= i_state_nxt;
         i_cnt         <= i_cnt_nxt;
         i_addr_q      <= i_addr_nxt;
         imem_complete <= i_go_c;
         if (i_go_c) imem_dout <= i_inr_c ? mem[i_idx_c] : '0;
      end
   end

   // ---------------- data port ----------------
   logic [1:0]        d_state, d_state_nxt;
   logic [DCNT_W-1:0] d_cnt, d_cnt_nxt;
   logic [ADDR_W-1:0] d_addr_q, d_addr_nxt;
   logic              d_rd_q, d_rd_nxt;
   logic [DATA_W-1:0] d_din_q, d_din_nxt;
   logic              d_go_c;
   logic [ADDR_W-1:0] d_addr_c, d_off_c;
   logic              d_rd_c;
   logic [DATA_W-1:0] d_din_c;
   logic              d_inr_c;
   logic [IDX_W-1:0]  d_idx_c;

   always_comb begin
      d_addr_c = (d_state == ST_IDLE) ? dmem_addr : d_addr_q;
      d_rd_c   = (d_state == ST_IDLE) ? dmem_rd   : d_rd_q;
      d_din_c  = (d_state == ST_IDLE) ? dmem_din  : d_din_q;
      d_off_c  = d_addr_c - BASE_ADDR;
      d_inr_c  = CMP_W'(d_off_c) < CMP_W'(MEM_DEPTH);
      d_idx_c  = d_off_c[IDX_W-1:0];
   end

   always_comb begin
      d_state_nxt = d_state;
      d_cnt_nxt   = d_cnt;
      d_addr_nxt  = d_addr_q;
      d_rd_nxt    = d_rd_q;
      d_din_nxt   = d_din_q;
      d_go_c      = 1'b0;
      case (d_state)
         ST_IDLE: begin
            if (dmem_req) begin
               d_addr_nxt = dmem_addr;
               d_rd_nxt   = dmem_rd;
               d_din_nxt  = dmem_din;
               if (DMEM_LAT == 1) begin
                  d_state_nxt = ST_RESP;
                  d_go_c      = 1'b1;
               end else begin
                  d_state_nxt = ST_WAIT;
                  d_cnt_nxt   = DCNT_W'(DMEM_LAT - 1);
               end
            end
         end
         ST_WAIT: begin
            d_cnt_nxt = d_cnt - DCNT_W'(1);
            if (d_cnt == DCNT_W'(1)) begin
               d_state_nxt = ST_RESP;
               d_go_c      = 1'b1;
            end
         end
         ST_RESP: d_state_nxt = ST_IDLE;
         default: d_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         d_state       <= ST_IDLE;
         d_cnt         <= '0;
         d_addr_q      <= '0;
         d_rd_q        <= 1'b0;
         d_din_q       <= '0;
         dmem_dout     <= '0;
         dmem_complete <= 1'b0;
      end else begin
         d_state       <= d_state_nxt;
         d_cnt         <= d_cnt_nxt;
         d_addr_q      <= d_addr_nxt;
         d_rd_q        <= d_rd_nxt;
         d_din_q       <= d_din_nxt;
         dmem_complete <= d_go_c;
         if (d_go_c && d_rd_c) dmem_dout <= d_inr_c ? mem[d_idx_c] : '0;
      end
   end

   // ---------------- preload, array, error flag ----------------
   logic [ADDR_W-1:0] ld_off_c;
   logic              ld_inr_c;
   logic [IDX_W-1:0]  ld_idx_c;

   always_comb begin
      ld_off_c = ld_addr - BASE_ADDR;
      ld_inr_c = CMP_W'(ld_off_c) < CMP_W'(MEM_DEPTH);
      ld_idx_c = ld_off_c[IDX_W-1:0];
   end

   // Data-port write is placed last so it wins over a same-edge preload
   always_ff @(posedge clock) begin
      if (ld_en && ld_inr_c) mem[ld_idx_c] <= ld_data;
      if (d_go_c && !d_rd_c && d_inr_c) mem[d_idx_c] <= d_din_c;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err_oob <= 1'b0;
      end else if ((i_go_c && !i_inr_c) || (d_go_c && !d_inr_c) || (ld_en && !ld_inr_c)) begin
         err_oob <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Scoreboard bench for lc3_mem_responder: a cycle model predicts completions and
// read data, the monitor pops expectations when the DUT completes.
module tb_lc3_mem_responder;

   localparam int IL    = 1;
   localparam int DL    = 3;
   localparam int DEPTH = 256;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_rd;
   logic [15:0] imem_addr;
   logic [15:0] imem_dout;
   logic        imem_complete;
   logic        dmem_req;
   logic        dmem_rd;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_din;
   logic [15:0] dmem_dout;
   logic        dmem_complete;
   logic        ld_en;
   logic [15:0] ld_addr;
   logic [15:0] ld_data;
   logic        err_oob;

   int checks = 0;
   int errors = 0;

   lc3_mem_responder #(
      .ADDR_W(16), .DATA_W(16), .MEM_DEPTH(DEPTH), .BASE_ADDR(16'h3000),
      .IMEM_LAT(IL), .DMEM_LAT(DL)
   ) u_dut (
      .clock(clock), .reset(reset),
      .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_dout(imem_dout),
      .imem_complete(imem_complete),
      .dmem_req(dmem_req), .dmem_rd(dmem_rd), .dmem_addr(dmem_addr),
      .dmem_din(dmem_din), .dmem_dout(dmem_dout), .dmem_complete(dmem_complete),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .err_oob(err_oob)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] val(input int i);
      if (i == 0)  return 16'h1234;
      if (i == 16) return 16'h0001;
      return 16'(i * 257) ^ 16'h5A00;
   endfunction

   function automatic int idx(input logic [15:0] a);
      logic [15:0] o;
      o = a - 16'h3000;
      return int'(o);
   endfunction

   // ---------------- reference model ----------------
   logic [15:0] mem_m [DEPTH];
   int          i_st, i_rem, d_st, d_rem;
   logic [15:0] i_cap, d_cap, d_cap_din;
   logic        d_cap_rd;
   logic        err_m, exp_icomp, exp_dcomp, do_i, do_d;
   logic [15:0] i_dout_m, d_dout_m;
   logic [15:0] iq[$];
   logic [15:0] dq[$];
   int          n_dcomp = 0;

   // States: 0 idle, 1 waiting, 2 responding (strobe ignored on the way out)
   initial forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
         i_st = 0; d_st = 0; err_m = 1'b0;
         i_dout_m = '0; d_dout_m = '0;
         exp_icomp = 1'b0; exp_dcomp = 1'b0;
         iq.delete(); dq.delete();
      end else begin
         exp_icomp = 1'b0; exp_dcomp = 1'b0; do_i = 1'b0; do_d = 1'b0;
         if (i_st == 2) i_st = 0;
         else begin
            if (i_st == 0 && imem_rd) begin i_st = 1; i_rem = IL; i_cap = imem_addr; end
            if (i_st == 1) begin
               i_rem--;
               if (i_rem == 0) begin do_i = 1'b1; i_st = 2; end
            end
         end
         if (d_st == 2) d_st = 0;
         else begin
            if (d_st == 0 && dmem_req) begin
               d_st = 1; d_rem = DL; d_cap = dmem_addr; d_cap_rd = dmem_rd; d_cap_din = dmem_din;
            end
            if (d_st == 1) begin
               d_rem--;
               if (d_rem == 0) begin do_d = 1'b1; d_st = 2; end
            end
         end
         if (do_i) begin
            if (idx(i_cap) < DEPTH) i_dout_m = mem_m[idx(i_cap)];
            else begin i_dout_m = '0; err_m = 1'b1; end
            exp_icomp = 1'b1;
            iq.push_back(i_dout_m);
         end
         if (do_d) begin
            if (idx(d_cap) >= DEPTH) err_m = 1'b1;
            if (d_cap_rd) d_dout_m = (idx(d_cap) < DEPTH) ? mem_m[idx(d_cap)] : 16'h0000;
            exp_dcomp = 1'b1;
            dq.push_back(d_dout_m);
         end
         if (ld_en) begin
            if (idx(ld_addr) < DEPTH) mem_m[idx(ld_addr)] = ld_data;
            else err_m = 1'b1;
         end
         if (do_d && !d_cap_rd && idx(d_cap) < DEPTH) mem_m[idx(d_cap)] = d_cap_din;
      end
   end

   // ---------------- monitor ----------------
   initial forever begin
      @(negedge clock);
      if (reset) begin
         check("icomp", 32'(imem_complete), 32'(exp_icomp));
         check("dcomp", 32'(dmem_complete), 32'(exp_dcomp));
         check("err", 32'(err_oob), 32'(err_m));
         if (imem_complete) begin
            check("iq_avail", 32'(iq.size() > 0), 32'(1));
            if (iq.size() > 0) check("idout", 32'(imem_dout), 32'(iq.pop_front()));
         end
         if (dmem_complete) begin
            n_dcomp++;
            check("dq_avail", 32'(dq.size() > 0), 32'(1));
            if (dq.size() > 0) check("ddout", 32'(dmem_dout), 32'(dq.pop_front()));
         end
      end
   end

   task automatic fetch(input logic [15:0] a, input logic [15:0] exp, input string tag);
      imem_rd = 1'b1; imem_addr = a;
      tick();
      imem_rd = 1'b0;
      @(negedge clock);
      check(tag, 32'(imem_dout), 32'(exp));
      tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n0;
      reset = 1'b1; imem_rd = 1'b0; imem_addr = '0;
      dmem_req = 1'b0; dmem_rd = 1'b0; dmem_addr = '0; dmem_din = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      #3 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_idout", 32'(imem_dout), 32'(0));
      check("rst_icomp", 32'(imem_complete), 32'(0));
      check("rst_ddout", 32'(dmem_dout), 32'(0));
      check("rst_dcomp", 32'(dmem_complete), 32'(0));
      check("rst_err", 32'(err_oob), 32'(0));
      reset = 1'b1;
      tick();

      for (int i = 0; i < DEPTH; i++) begin
         ld_en = 1'b1; ld_addr = 16'(16'h3000 + i); ld_data = val(i);
         tick();
      end
      ld_en = 1'b0;
      tick();

      // Single-cycle fetch: pulse lasts exactly one cycle
      imem_rd = 1'b1; imem_addr = 16'h3000;
      tick();
      imem_rd = 1'b0;
      @(negedge clock);
      check("fetch_pulse", 32'(imem_complete), 32'(1));
      check("fetch_data", 32'(imem_dout), 32'h1234);
      tick();
      @(negedge clock);
      check("fetch_pulse_end", 32'(imem_complete), 32'(0));
      tick();

      // Write then read back on the data port
      dmem_req = 1'b1; dmem_rd = 1'b0; dmem_addr = 16'h3005; dmem_din = 16'hBEEF;
      tick();
      dmem_req = 1'b0;
      repeat (4) tick();
      dmem_req = 1'b1; dmem_rd = 1'b1; dmem_addr = 16'h3005;
      tick();
      dmem_req = 1'b0;
      repeat (2) tick();
      @(negedge clock);
      check("dread_pulse", 32'(dmem_complete), 32'(1));
      check("dread_beef", 32'(dmem_dout), 32'hBEEF);
      repeat (3) tick();

      // Back-to-back strobes: only requests spaced LAT+1 apart are served
      n0 = n_dcomp;
      for (int k = 0; k < 5; k++) begin
         dmem_req = 1'b1; dmem_rd = 1'b1; dmem_addr = 16'(16'h3000 + k);
         tick();
      end
      dmem_req = 1'b0;
      repeat (6) tick();
      check("dspacing", 32'(n_dcomp - n0), 32'(2));
      for (int k = 0; k < 4; k++) begin
         imem_rd = 1'b1; imem_addr = 16'(16'h3040 + k);
         tick();
      end
      imem_rd = 1'b0;
      repeat (3) tick();

      // Out-of-range read and write
      fetch(16'h2FFF, 16'h0000, "oob_rdata");
      check("oob_err_set", 32'(err_oob), 32'(1));
      dmem_req = 1'b1; dmem_rd = 1'b0; dmem_addr = 16'h3100; dmem_din = 16'hFFFF;
      tick();
      dmem_req = 1'b0;
      repeat (4) tick();
      check("oob_err_sticky", 32'(err_oob), 32'(1));
      fetch(16'h3000, 16'h1234, "oob_nowrite");

      // Same-edge fetch and data write: fetch sees the old word
      dmem_req = 1'b1; dmem_rd = 1'b0; dmem_addr = 16'h3010; dmem_din = 16'h0002;
      tick();
      dmem_req = 1'b0;
      tick();
      fetch(16'h3010, 16'h0001, "collide_old");
      tick();
      fetch(16'h3010, 16'h0002, "collide_new");

      // Same-edge preload and data write: data write wins
      dmem_req = 1'b1; dmem_rd = 1'b0; dmem_addr = 16'h3011; dmem_din = 16'hAAAA;
      tick();
      dmem_req = 1'b0;
      tick();
      ld_en = 1'b1; ld_addr = 16'h3011; ld_data = 16'h5555;
      tick();
      ld_en = 1'b0;
      tick();
      fetch(16'h3011, 16'hAAAA, "ld_vs_dwrite");

      // Reset while a write is waiting: write and pulse are abandoned
      dmem_req = 1'b1; dmem_rd = 1'b0; dmem_addr = 16'h3020; dmem_din = 16'hDEAD;
      tick();
      dmem_req = 1'b0;
      #2 reset = 1'b0;
      #1;
      check("mid_rst_idout", 32'(imem_dout), 32'(0));
      check("mid_rst_icomp", 32'(imem_complete), 32'(0));
      check("mid_rst_ddout", 32'(dmem_dout), 32'(0));
      check("mid_rst_dcomp", 32'(dmem_complete), 32'(0));
      check("mid_rst_err", 32'(err_oob), 32'(0));
      repeat (2) tick();
      reset = 1'b1;
      n0 = n_dcomp;
      repeat (5) tick();
      check("rst_no_dcomp", 32'(n_dcomp - n0), 32'(0));
      fetch(16'h3020, val(32), "rst_nowrite");
      check("rst_err_clear", 32'(err_oob), 32'(0));

      // Out-of-range preload sets the flag
      ld_en = 1'b1; ld_addr = 16'h4000; ld_data = 16'h7777;
      tick();
      ld_en = 1'b0;
      @(negedge clock);
      check("ld_oob_err", 32'(err_oob), 32'(1));
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
